mar_burst: RTL and testbench

MAR_BURST -- requirements
Module: mar_burst

---
 rtl/mar_pkg.sv | 13 +
 rtl/mar_burst.sv | 102 ++++++++++
 tb/tb_mar_burst.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mar_pkg.sv
// Shared definitions for the memory address register burst engine:
// the FSM state type and the default widths used by mar_burst.
package mar_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned LEN_W_DEF  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage : mar_pkg

// File: rtl/mar_burst.sv
// Memory address register with load/post-increment in IDLE and a
// ready/valid sequential burst engine that walks addresses in BURST.
module mar_burst
  import mar_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mar_in,
  input  logic              mar_inc,
  input  logic [ADDR_W-1:0] mar_bus,
  input  logic              burst_start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              ram_ready,
  output logic [ADDR_W-1:0] mar_add,
  output logic              add_valid,
  output logic              busy,
  output logic              burst_done,
  output logic              wrap
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_wrap;

  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [LEN_W-1:0]    w_cnt_nxt;
  logic                w_done_nxt;
  logic                w_wrap_nxt;
  logic                w_inc;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_inc       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (burst_start) begin
          // mar_in selects the burst base; mar_inc is ignored this cycle
          w_state_nxt = BURST;
          w_cnt_nxt   = burst_len;
          if (mar_in) w_addr_nxt = mar_bus;
        end else if (mar_in) begin
          w_addr_nxt = mar_bus;
        end else if (mar_inc) begin
          w_inc = 1'b1;
        end
      end
      BURST: begin
        if (ram_ready) begin
          w_inc = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_inc) w_addr_nxt = r_addr + ADDR_W'(1);
    w_wrap_nxt = w_inc && (r_addr == '1);
  end

  // NOTE: state registers use non-blocking assignments so all of them
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign mar_add    = r_addr;
  assign add_valid  = (r_state == BURST);
  assign busy       = (r_state == BURST);
  assign burst_done = r_done;
  assign wrap       = r_wrap;

endmodule : mar_burst

// File: tb/tb_mar_burst.sv
// Self-checking bench for mar_burst: directed scenarios plus a randomized
// transaction run checked against a transaction-level address model.
module tb_mar_burst;

  logic       clk;
  logic       rst_n;
  logic       mar_in;
  logic       mar_inc;
  logic [3:0] mar_bus;
  logic       burst_start;
  logic [2:0] burst_len;
  logic       ram_ready;
  logic [3:0] mar_add;
  logic       add_valid;
  logic       busy;
  logic       burst_done;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  mar_burst #(.ADDR_W(4), .LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mar_in(mar_in), .mar_inc(mar_inc),
    .mar_bus(mar_bus), .burst_start(burst_start), .burst_len(burst_len),
    .ram_ready(ram_ready), .mar_add(mar_add), .add_valid(add_valid),
    .busy(busy), .burst_done(burst_done), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {mar_add, add_valid, busy, burst_done, wrap}
  logic [7:0] obs;
  assign obs = {mar_add, add_valid, busy, burst_done, wrap};

  function automatic logic [7:0] ev(input logic [3:0] a, input logic v,
                                    input logic d, input logic w);
    return {a, v, v, d, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mar_in = 0; mar_inc = 0; burst_start = 0; mar_bus = 0;
    burst_len = 0; ram_ready = 0;
  endtask

  task automatic load(input logic [3:0] a);
    mar_in = 1; mar_bus = a; tick(); mar_in = 0;
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 0;
    #2;
    n_cmp++; if (obs !== ev(4'h0, 0, 0, 0)) begin n_bad++; $display("FAIL reset: got %h want %h", obs, ev(4'h0, 0, 0, 0)); end
    @(negedge clk); rst_n = 1;
    tick();
    n_cmp++; if (obs !== ev(4'h0, 0, 0, 0)) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs, ev(4'h0, 0, 0, 0)); end
  endtask

  task automatic test_load();
    mar_in = 1; mar_inc = 1; mar_bus = 4'b0110; tick();
    n_cmp++; if (obs !== ev(4'h6, 0, 0, 0)) begin n_bad++; $display("FAIL load_6: got %h want %h", obs, ev(4'h6, 0, 0, 0)); end
    mar_inc = 0; mar_bus = 4'b1010; tick();
    n_cmp++; if (obs !== ev(4'hA, 0, 0, 0)) begin n_bad++; $display("FAIL load_10: got %h want %h", obs, ev(4'hA, 0, 0, 0)); end
    quiet();
  endtask

  task automatic test_inc_wrap();
    load(4'hE);
    mar_inc = 1; tick();
    n_cmp++; if (obs !== ev(4'hF, 0, 0, 0)) begin n_bad++; $display("FAIL inc_F: got %h want %h", obs, ev(4'hF, 0, 0, 0)); end
    tick();
    n_cmp++; if (obs !== ev(4'h0, 0, 0, 1)) begin n_bad++; $display("FAIL inc_wrap0: got %h want %h", obs, ev(4'h0, 0, 0, 1)); end
    mar_inc = 0; tick();
    n_cmp++; if (obs !== ev(4'h0, 0, 0, 0)) begin n_bad++; $display("FAIL wrap_single: got %h want %h", obs, ev(4'h0, 0, 0, 0)); end
  endtask

  task automatic test_burst();
    load(4'h3);
    burst_start = 1; burst_len = 3; ram_ready = 1; tick();
    burst_start = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs !== ev(4'(3 + i), 1, 0, 0)) begin n_bad++; $display("FAIL burst_beat%0d: got %h want %h", i, obs, ev(4'(3 + i), 1, 0, 0)); end
      tick();
    end
    n_cmp++; if (obs !== ev(4'h7, 0, 1, 0)) begin n_bad++; $display("FAIL burst_done: got %h want %h", obs, ev(4'h7, 0, 1, 0)); end
    quiet(); tick();
    n_cmp++; if (obs !== ev(4'h7, 0, 0, 0)) begin n_bad++; $display("FAIL burst_after: got %h want %h", obs, ev(4'h7, 0, 0, 0)); end
  endtask

  task automatic test_backpressure();
    load(4'h8);
    burst_start = 1; burst_len = 1; ram_ready = 0; tick();
    burst_start = 0;
    for (int i = 0; i < 3; i++) begin
      ram_ready = (i == 2);
      n_cmp++; if (obs !== ev(4'h8, 1, 0, 0)) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i, obs, ev(4'h8, 1, 0, 0)); end
      tick();
    end
    n_cmp++; if (obs !== ev(4'h9, 1, 0, 0)) begin n_bad++; $display("FAIL bp_beat9: got %h want %h", obs, ev(4'h9, 1, 0, 0)); end
    tick();
    n_cmp++; if (obs !== ev(4'hA, 0, 1, 0)) begin n_bad++; $display("FAIL bp_done: got %h want %h", obs, ev(4'hA, 0, 1, 0)); end
    quiet(); tick();
    n_cmp++; if (obs !== ev(4'hA, 0, 0, 0)) begin n_bad++; $display("FAIL bp_done_once: got %h want %h", obs, ev(4'hA, 0, 0, 0)); end
  endtask

  task automatic test_wrap_burst();
    load(4'h5);
    mar_in = 1; mar_bus = 4'hE; burst_start = 1; burst_len = 2; ram_ready = 1; tick();
    mar_in = 0; burst_start = 0;
    n_cmp++; if (obs !== ev(4'hE, 1, 0, 0)) begin n_bad++; $display("FAIL wb_E: got %h want %h", obs, ev(4'hE, 1, 0, 0)); end
    tick();
    n_cmp++; if (obs !== ev(4'hF, 1, 0, 0)) begin n_bad++; $display("FAIL wb_F: got %h want %h", obs, ev(4'hF, 1, 0, 0)); end
    tick();
    n_cmp++; if (obs !== ev(4'h0, 1, 0, 1)) begin n_bad++; $display("FAIL wb_0: got %h want %h", obs, ev(4'h0, 1, 0, 1)); end
    tick();
    n_cmp++; if (obs !== ev(4'h1, 0, 1, 0)) begin n_bad++; $display("FAIL wb_done: got %h want %h", obs, ev(4'h1, 0, 1, 0)); end
    quiet();
  endtask

  task automatic test_reset_mid_burst();
    load(4'h5);
    burst_start = 1; burst_len = 4; ram_ready = 1; tick();
    burst_start = 0;
    tick(); tick();
    n_cmp++; if (obs !== ev(4'h7, 1, 0, 0)) begin n_bad++; $display("FAIL rm_pre: got %h want %h", obs, ev(4'h7, 1, 0, 0)); end
    rst_n = 0; #1;
    n_cmp++; if (obs !== ev(4'h0, 0, 0, 0)) begin n_bad++; $display("FAIL rm_async: got %h want %h", obs, ev(4'h0, 0, 0, 0)); end
    quiet(); tick();
    @(negedge clk); rst_n = 1;
    n_cmp++; if (obs !== ev(4'h0, 0, 0, 0)) begin n_bad++; $display("FAIL rm_release: got %h want %h", obs, ev(4'h0, 0, 0, 0)); end
    mar_inc = 1; tick(); mar_inc = 0;
    n_cmp++; if (obs !== ev(4'h1, 0, 0, 0)) begin n_bad++; $display("FAIL rm_inc: got %h want %h", obs, ev(4'h1, 0, 0, 0)); end
  endtask

  task automatic test_back_to_back();
    load(4'h2);
    burst_start = 1; burst_len = 1; ram_ready = 1; tick();
    burst_start = 0; tick(); tick();
    n_cmp++; if (obs !== ev(4'h4, 0, 1, 0)) begin n_bad++; $display("FAIL b2b_done1: got %h want %h", obs, ev(4'h4, 0, 1, 0)); end
    burst_start = 1; burst_len = 0; mar_inc = 1; tick();
    burst_start = 0; mar_inc = 0;
    n_cmp++; if (obs !== ev(4'h4, 1, 0, 0)) begin n_bad++; $display("FAIL b2b_accept: got %h want %h", obs, ev(4'h4, 1, 0, 0)); end
    tick();
    n_cmp++; if (obs !== ev(4'h5, 0, 1, 0)) begin n_bad++; $display("FAIL b2b_done2: got %h want %h", obs, ev(4'h5, 0, 1, 0)); end
    quiet(); tick();
  endtask

  // Transaction-level model: the address is an integer mod 16; a burst of
  // len+1 beats from base visits base..base+len and ends at base+len+1.
  task automatic test_random();
    logic [3:0] m_addr;
    m_addr = mar_add;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_start_idle: busy=%b want 0", busy); end
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        logic [3:0] b;
        b = 4'($urandom);
        mar_in = 1; mar_bus = b; mar_inc = 1'($urandom); tick(); quiet();
        m_addr = b;
        n_cmp++; if (obs !== ev(m_addr, 0, 0, 0)) begin n_bad++; $display("FAIL rnd_load t%0d: got %h want %h", t, obs, ev(m_addr, 0, 0, 0)); end
      end else if (kind == 1) begin
        logic w_exp;
        w_exp = (m_addr == 4'hF);
        mar_inc = 1; tick(); quiet();
        m_addr = 4'((int'(m_addr) + 1) % 16);
        n_cmp++; if (obs !== ev(m_addr, 0, 0, w_exp)) begin n_bad++; $display("FAIL rnd_inc t%0d: got %h want %h", t, obs, ev(m_addr, 0, 0, w_exp)); end
      end else begin
        int len, base, beat, cyc, wraps, exp_wraps;
        logic use_load, rdy;
        logic [3:0] b;
        len = $urandom_range(0, 7);
        use_load = 1'($urandom);
        b = 4'($urandom);
        mar_in = use_load; mar_bus = b; mar_inc = 1'($urandom);
        burst_start = 1; burst_len = 3'(len); tick();
        base = use_load ? int'(b) : int'(m_addr);
        beat = 0; cyc = 0; wraps = 0;
        exp_wraps = 0;
        for (int k = 0; k <= len; k++) if ((base + k) % 16 == 15) exp_wraps++;
        while (beat <= len && cyc < 200) begin
          rdy = 1'($urandom);
          ram_ready = rdy; mar_in = 1'($urandom); mar_inc = 1'($urandom);
          burst_start = 1'($urandom); mar_bus = 4'($urandom); burst_len = 3'($urandom);
          n_cmp++; if ({mar_add, add_valid, busy, burst_done} !== {4'((base + beat) % 16), 3'b110}) begin n_bad++; $display("FAIL rnd_beat t%0d b%0d: got %h want %h", t, beat, {mar_add, add_valid, busy, burst_done}, {4'((base + beat) % 16), 3'b110}); end
          tick();
          if (wrap) wraps++;
          if (rdy) beat++;
          cyc++;
        end
        quiet();
        n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL rnd_timeout t%0d: beats=%0d want %0d", t, beat, len + 1); end
        m_addr = 4'((base + len + 1) % 16);
        n_cmp++; if ({mar_add, add_valid, busy, burst_done} !== {m_addr, 3'b001}) begin n_bad++; $display("FAIL rnd_done t%0d: got %h want %h", t, {mar_add, add_valid, busy, burst_done}, {m_addr, 3'b001}); end
        n_cmp++; if (wraps != exp_wraps) begin n_bad++; $display("FAIL rnd_wraps t%0d: got %0d want %0d", t, wraps, exp_wraps); end
      end
    end
  endtask

  initial begin
    quiet();
    rst_n = 0;
    test_reset();
    test_load();
    test_inc_wrap();
    test_burst();
    test_backpressure();
    test_wrap_burst();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mar_burst
